jk_excitation_driver: RTL and testbench



---
 rtl/jk_excitation_driver.sv | 157 +++++++++++++++
 tb/tb_jk_excitation_driver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//
// Purpose:
//   Drives a bank of WIDTH JK flip-flops toward a requested target word.
//   A target is accepted over a valid/ready handshake. The driver computes
//   per-bit J/K excitation against a shadow copy of the bank state and
//   issues it with a one-cycle strobe. It then waits SETTLE_CYCLES cycles,
//   reads back the bank Q outputs, and reports done and mismatch.
//
// Parameters:
//   WIDTH          number of JK flip-flops driven (1..32)
//   SETTLE_CYCLES  idle cycles between drive strobe and readback (0..255)
//
// Ports:
//   Clk_In            system clock, rising edge
//   Reset_In          synchronous active-high reset
//   Target_In         requested bank state
//   Target_Valid_In   Target_In valid
//   Target_Ready_Out  driver can accept a target (high in IDLE)
//   J_Out / K_Out     excitation to the bank, valid with Drive_Strobe_Out
//   Drive_Strobe_Out  one-cycle pulse, bank applies J_Out/K_Out
//   Q_Fb_In           Q readback from the bank
//   Done_Out          one-cycle pulse, operation complete
//   Mismatch_Out      one-cycle pulse with Done_Out when readback != target
//
// Optional feature macro:
//   JK_DRIVER_TOGGLE_EN  when defined, every differing bit is driven with
//                        J=K=1 (toggle) instead of set/clear codes.
//
// Latency (acceptance edge = cycle 0):
//   strobe in cycle 1, done in cycle 2+SETTLE_CYCLES, and ready again in
//   cycle 3+SETTLE_CYCLES.
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             Clk_In,
  input  logic             Reset_In,
  input  logic [WIDTH-1:0] Target_In,
  input  logic             Target_Valid_In,
  output logic             Target_Ready_Out,
  output logic [WIDTH-1:0] J_Out,
  output logic [WIDTH-1:0] K_Out,
  output logic             Drive_Strobe_Out,
  input  logic [WIDTH-1:0] Q_Fb_In,
  output logic             Done_Out,
  output logic             Mismatch_Out
);

  // Settle counter: ceil(log2(SETTLE_CYCLES+1)) bits, never narrower than 1.
  localparam int unsigned CNT_W       = (SETTLE_CYCLES == 0) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_LAST);
  localparam logic             NO_SETTLE = (SETTLE_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] j_q;
  logic [WIDTH-1:0] k_q;
  logic             strobe_q;
  logic             done_q;
  logic             mismatch_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic             accept;
  logic             check_en;

  // Handshake and excitation computed from the live target and the shadow.
  always_comb begin
    accept   = Target_Valid_In && (state_q == ST_IDLE);
    check_en = ((state_q == ST_DRIVE) && NO_SETTLE) ||
               ((state_q == ST_SETTLE) && (cnt_q == CNT_LAST));
`ifdef JK_DRIVER_TOGGLE_EN
    j_d = Target_In ^ shadow_q;
    k_d = Target_In ^ shadow_q;
`else
    j_d = Target_In & ~shadow_q;
    k_d = shadow_q & ~Target_In;
`endif
  end

  // Control FSM with registered outputs. Pulses default low every cycle.
  // Readback is sampled on the edge that enters CHECK. As a result, Done and
  // Mismatch are high during CHECK, and the shadow holds the bank's actual
  // state, not the target.
  always_ff @(posedge Clk_In) begin
    if (Reset_In) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      target_q   <= '0;
      j_q        <= '0;
      k_q        <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      j_q        <= '0;
      k_q        <= '0;

      if (check_en) begin
        state_q    <= ST_CHECK;
        done_q     <= 1'b1;
        mismatch_q <= (Q_Fb_In != target_q);
        shadow_q   <= Q_Fb_In;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (accept) begin
              target_q <= Target_In;
              j_q      <= j_d;
              k_q      <= k_d;
              strobe_q <= 1'b1;
              state_q  <= ST_DRIVE;
            end
          end
          ST_DRIVE: begin
            cnt_q   <= '0;
            state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
          ST_CHECK: begin
            state_q <= ST_IDLE;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign Target_Ready_Out = (state_q == ST_IDLE);
  assign J_Out            = j_q;
  assign K_Out            = k_q;
  assign Drive_Strobe_Out = strobe_q;
  assign Done_Out         = done_q;
  assign Mismatch_Out     = mismatch_q;

endmodule

// File: tb/tb_jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_driver
//
// Purpose:
//   Self-checking bench for jk_excitation_driver with WIDTH=8 and
//   SETTLE_CYCLES=2. A JK bank model applies J/K on the strobe. The
//   readback can be overridden to create mismatches. Expected excitation,
//   timing and flags come from the spec rules:
//     excitation = target vs shadow
//     shadow     = last readback
//     done       = cycle 2+S
// ---------------------------------------------------------------------------
module tb_jk_excitation_driver;

  localparam int unsigned W = 8;
  localparam int unsigned S = 2;

  logic         clk = 1'b0;
  logic         Reset_In;
  logic [W-1:0] Target_In;
  logic         Target_Valid_In;
  logic         Target_Ready_Out;
  logic [W-1:0] J_Out;
  logic [W-1:0] K_Out;
  logic         Drive_Strobe_Out;
  logic [W-1:0] Q_Fb_In;
  logic         Done_Out;
  logic         Mismatch_Out;

  jk_excitation_driver #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .Clk_In           (clk),
    .Reset_In         (Reset_In),
    .Target_In        (Target_In),
    .Target_Valid_In  (Target_Valid_In),
    .Target_Ready_Out (Target_Ready_Out),
    .J_Out            (J_Out),
    .K_Out            (K_Out),
    .Drive_Strobe_Out (Drive_Strobe_Out),
    .Q_Fb_In          (Q_Fb_In),
    .Done_Out         (Done_Out),
    .Mismatch_Out     (Mismatch_Out)
  );

  always #5 clk = ~clk;

  // JK bank environment: 00 hold, 10 set, 01 clear, 11 toggle.
  logic [W-1:0] bank_q;
  logic         fb_force;
  logic [W-1:0] fb_val;
  always @(posedge clk) begin
    if (Reset_In)
      bank_q <= '0;
    else if (Drive_Strobe_Out)
      bank_q <= (bank_q & ~J_Out & ~K_Out) | (J_Out & ~K_Out) | (~bank_q & J_Out & K_Out);
  end
  assign Q_Fb_In = fb_force ? fb_val : bank_q;

  int strobe_cnt = 0;
  always @(negedge clk) if (Drive_Strobe_Out === 1'b1) strobe_cnt <= strobe_cnt + 1;

  int checks = 0;
  int errors = 0;

  // Reference model state: shadow register and bank contents, held abstractly.
  logic [W-1:0] m_shadow;
  logic [W-1:0] m_bank;
  logic [W-1:0] held_tgt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the acceptance edge. Walks cycles 1..2+S.
  // mode 0: valid low, 1: random valid noise, 2: hold valid with held_tgt.
  task automatic track(input logic [W-1:0] tgt, input logic frc, input logic [W-1:0] fbv,
                       input int mode);
    logic [W-1:0] ej, ek, rb;
`ifdef JK_DRIVER_TOGGLE_EN
    ej = tgt ^ m_shadow;
    ek = tgt ^ m_shadow;
    m_bank = m_bank ^ (tgt ^ m_shadow);
`else
    ej = tgt & ~m_shadow;
    ek = m_shadow & ~tgt;
    m_bank = (m_bank & ~ek) | ej;
`endif
    rb = frc ? fbv : m_bank;
    for (int c = 1; c <= int'(S) + 2; c++) begin
      @(negedge clk);
      if (mode == 2) begin
        Target_Valid_In = 1'b1;
        Target_In       = held_tgt;
      end else begin
        Target_Valid_In = (mode == 1) ? 1'($urandom) : 1'b0;
        Target_In       = W'($urandom);
      end
      chk("busy_ready", {31'd0, Target_Ready_Out}, 32'd0);
      chk("strobe", {31'd0, Drive_Strobe_Out}, (c == 1) ? 32'd1 : 32'd0);
      chk("j_out", {24'd0, J_Out}, (c == 1) ? {24'd0, ej} : 32'd0);
      chk("k_out", {24'd0, K_Out}, (c == 1) ? {24'd0, ek} : 32'd0);
      chk("done", {31'd0, Done_Out}, (c == int'(S) + 2) ? 32'd1 : 32'd0);
      chk("mismatch", {31'd0, Mismatch_Out},
          ((c == int'(S) + 2) && (rb != tgt)) ? 32'd1 : 32'd0);
    end
    m_shadow = rb;
  endtask

  task automatic finish_idle();
    @(negedge clk);
    Target_Valid_In = 1'b0;
    fb_force        = 1'b0;
    chk("ready_back", {31'd0, Target_Ready_Out}, 32'd1);
    chk("idle_done", {31'd0, Done_Out}, 32'd0);
    chk("idle_mm", {31'd0, Mismatch_Out}, 32'd0);
    chk("idle_strobe", {31'd0, Drive_Strobe_Out}, 32'd0);
  endtask

  // Starts at a negedge with the DUT idle.
  task automatic run_op(input logic [W-1:0] tgt, input logic frc, input logic [W-1:0] fbv,
                        input int mode);
    Target_In       = tgt;
    Target_Valid_In = 1'b1;
    fb_force        = frc;
    fb_val          = fbv;
    chk("ready_idle", {31'd0, Target_Ready_Out}, 32'd1);
    @(posedge clk);
    track(tgt, frc, fbv, mode);
    finish_idle();
  endtask

  initial begin
    int s0;
    Reset_In        = 1'b1;
    Target_In       = '0;
    Target_Valid_In = 1'b0;
    fb_force        = 1'b0;
    fb_val          = '0;
    m_shadow        = '0;
    m_bank          = '0;
    held_tgt        = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, Target_Ready_Out}, 32'd1);
    chk("rst_strobe", {31'd0, Drive_Strobe_Out}, 32'd0);
    chk("rst_j", {24'd0, J_Out}, 32'd0);
    chk("rst_k", {24'd0, K_Out}, 32'd0);
    chk("rst_done", {31'd0, Done_Out}, 32'd0);
    chk("rst_mm", {31'd0, Mismatch_Out}, 32'd0);
    Reset_In = 1'b0;
    @(negedge clk);

    // Directed sequence from the test plan
    run_op(8'h5A, 1'b0, 8'h00, 0);
    run_op(8'h0F, 1'b0, 8'h00, 0);
    run_op(8'h0F, 1'b1, 8'h0E, 0);
    run_op(8'h0F, 1'b0, 8'h00, 0);
    run_op(m_shadow, 1'b0, 8'h00, 0);

    // Valid held high: second target accepted only in cycle 3+S
    s0              = strobe_cnt;
    held_tgt        = 8'h3C;
    Target_In       = 8'hC3;
    Target_Valid_In = 1'b1;
    chk("held_ready0", {31'd0, Target_Ready_Out}, 32'd1);
    @(posedge clk);
    track(8'hC3, 1'b0, 8'h00, 2);
    @(negedge clk);
    chk("held_ready_c5", {31'd0, Target_Ready_Out}, 32'd1);
    @(posedge clk);
    track(8'h3C, 1'b0, 8'h00, 0);
    finish_idle();
    chk("held_strobes", 32'(strobe_cnt - s0), 32'd2);

    // Reset during SETTLE aborts with no done/mismatch
    Target_In       = 8'h77;
    Target_Valid_In = 1'b1;
    @(posedge clk);
    @(negedge clk);
    Target_Valid_In = 1'b0;
    chk("ab_strobe", {31'd0, Drive_Strobe_Out}, 32'd1);
    @(negedge clk);
    Reset_In = 1'b1;
    @(negedge clk);
    chk("ab_ready", {31'd0, Target_Ready_Out}, 32'd1);
    chk("ab_done", {31'd0, Done_Out}, 32'd0);
    chk("ab_mm", {31'd0, Mismatch_Out}, 32'd0);
    Reset_In = 1'b0;
    m_shadow = '0;
    m_bank   = '0;
    @(negedge clk);
    chk("ab_done2", {31'd0, Done_Out}, 32'd0);
    chk("ab_mm2", {31'd0, Mismatch_Out}, 32'd0);
    run_op(8'h01, 1'b0, 8'h00, 0);

    // Randomized operations with busy-time valid noise and forced readbacks
    for (int i = 0; i < 24; i++) begin
      logic [W-1:0] t, f;
      logic         frc;
      t   = W'($urandom);
      f   = W'($urandom);
      frc = ($urandom_range(0, 3) == 0);
      run_op(t, frc, f, 1);
      if ($urandom_range(0, 1) == 1) begin
        Target_In = W'($urandom);
        @(negedge clk);
        chk("gap_strobe", {31'd0, Drive_Strobe_Out}, 32'd0);
        chk("gap_ready", {31'd0, Target_Ready_Out}, 32'd1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
